// File: rtl/sort8_pkg.sv
// ---------------------------------------------------------------------------
// sort8_pkg: shared constants and tag type for the sort8 scheduler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sort8_pkg;
    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;
    localparam int LANES   = 8;
    localparam int VEC_W   = LANES * BYTE_W;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

`default_nettype wire

// File: rtl/sort8_sched_if.sv
// ---------------------------------------------------------------------------
// sort8_sched_if: requester, sorter and result-port bundle of sort8_sched. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sort8_sched_if;
    import sort8_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [VEC_W-1:0] req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic [VEC_W-1:0] req1_data;
    logic [VEC_W-1:0] srt_x;
    logic [VEC_W-1:0] srt_y;
    logic             res0_valid;
    logic             res0_ready;
    logic [VEC_W-1:0] res0_data;
    logic             res1_valid;
    logic             res1_ready;
    logic [VEC_W-1:0] res1_data;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, srt_y, res0_ready, res1_ready,
        output req0_ready, req1_ready, srt_x, res0_valid, res0_data, res1_valid, res1_data, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, srt_y, res0_ready, res1_ready,
        input  req0_ready, req1_ready, srt_x, res0_valid, res0_data, res1_valid, res1_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/sort8_res_fifo.sv
// ---------------------------------------------------------------------------
// sort8_res_fifo: show-ahead synchronous result FIFO with occupancy count. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sort8_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

`default_nettype wire

// File: rtl/sort8_sched.sv
// ---------------------------------------------------------------------------
// sort8_sched: round-robin, credit-gated sharing of one sort8 pipe by two requesters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sort8_sched
    import sort8_pkg::*;
#(
    parameter int PIPE_LAT   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    sort8_sched_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_CNT = (CW+1)'(FIFO_DEPTH);

    // Stage 0 travels alongside srt_x; stage PIPE_LAT lines up with srt_y.
    tag_t                            tag_q [0:PIPE_LAT];
    tag_t                            done;
    logic [VEC_W-1:0]                srt_x_q;
    logic                            last_grant_q;
    logic                            tag_busy;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              res_ready;
    logic [NUM_REQ-1:0]              eligible;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              fifo_push;
    logic [NUM_REQ-1:0]              fifo_valid;
    logic [NUM_REQ-1:0][VEC_W-1:0]   req_data;
    logic [NUM_REQ-1:0][VEC_W-1:0]   fifo_head;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_data  = {bus.req1_data, bus.req0_data};
    assign res_ready = {bus.res1_ready, bus.res0_ready};
    assign done      = tag_q[PIPE_LAT];

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= PIPE_LAT; s++) tag_q[s] <= '0;
            srt_x_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            tag_q[0].valid <= |grant;
            tag_q[0].id    <= grant[1];
            for (int s = 1; s <= PIPE_LAT; s++) tag_q[s] <= tag_q[s-1];
            if (|grant) begin
                srt_x_q      <= req_data[grant[1]];
                last_grant_q <= grant[1];
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic [CW-1:0] inflight_q;
        logic [CW-1:0] inflight_d;
        logic [CW-1:0] fifo_cnt;
        logic [CW:0]   used;

        assign fifo_push[i] = done.valid && (done.id == 1'(i));
        // Results already queued plus those still in the pipe bound the FIFO fill.
        assign used        = {1'b0, fifo_cnt} + {1'b0, inflight_q};
        assign eligible[i] = req_valid[i] && (used < DEPTH_CNT);

        always_comb begin
            inflight_d = inflight_q;
            if (grant[i] && !fifo_push[i]) begin
                inflight_d = inflight_q + CW'(1);
            end else if (!grant[i] && fifo_push[i]) begin
                inflight_d = inflight_q - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) inflight_q <= '0;
            else     inflight_q <= inflight_d;
        end

        sort8_res_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (VEC_W)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (fifo_push[i]),
            .push_data_i (bus.srt_y),
            .pop_i       (res_ready[i] && fifo_valid[i]),
            .valid_o     (fifo_valid[i]),
            .head_o      (fifo_head[i]),
            .count_o     (fifo_cnt)
        );
    end

    always_comb begin
        tag_busy = 1'b0;
        for (int s = 0; s <= PIPE_LAT; s++) tag_busy = tag_busy | tag_q[s].valid;
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.srt_x      = srt_x_q;
    assign bus.res0_valid = fifo_valid[0];
    assign bus.res0_data  = fifo_head[0];
    assign bus.res1_valid = fifo_valid[1];
    assign bus.res1_data  = fifo_head[1];
    assign bus.busy       = tag_busy || (|fifo_valid);
endmodule

`default_nettype wire
